// File: rtl/amm_pkg.sv
// Shared constants for the abs/min/max issue controller: data width, ALU op codes,
// controller state encoding and op-mask helpers.
package amm_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned MASK_W = 3;
    localparam int unsigned SEL_W  = 2;

    // 2'b11 is reserved and never driven.
    typedef enum logic [SEL_W-1:0] {
        OP_ABS = 2'b00,
        OP_MIN = 2'b01,
        OP_MAX = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_CAPT  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    // Lowest enabled op wins, giving the fixed ABS -> MIN -> MAX order.
    function automatic op_e first_op(input logic [MASK_W-1:0] m);
        op_e op;
        if (m[0]) begin
            op = OP_ABS;
        end else if (m[1]) begin
            op = OP_MIN;
        end else begin
            op = OP_MAX;
        end
        return op;
    endfunction

    function automatic logic [MASK_W-1:0] op_bit(input op_e op);
        logic [MASK_W-1:0] b;
        case (op)
            OP_ABS:  b = MASK_W'(3'b001);
            OP_MIN:  b = MASK_W'(3'b010);
            OP_MAX:  b = MASK_W'(3'b100);
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/amm_issue_ctrl.sv
// Sequences up to three ops (ABS, MIN, MAX) through an external registered ALU
// for one latched operand pair and presents the captured results with a handshake.
module amm_issue_ctrl
    import amm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [MASK_W-1:0] op_mask,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] res_abs,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_max,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e            state_q, state_d;
    op_e               sel_q, sel_d;
    logic [MASK_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_abs_q, res_abs_d;
    logic [DATA_W-1:0] res_min_q, res_min_d;
    logic [DATA_W-1:0] res_max_q, res_max_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              accept_c;

    assign accept_c = in_valid && in_ready_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= OP_ABS;
            pend_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_abs_q   <= '0;
            res_min_q   <= '0;
            res_max_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            pend_q      <= pend_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_abs_q   <= res_abs_d;
            res_min_q   <= res_min_d;
            res_max_q   <= res_max_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pend_d      = pend_q;
        a_d         = a_q;
        b_d         = b_q;
        res_abs_d   = res_abs_q;
        res_min_d   = res_min_q;
        res_max_d   = res_max_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    res_abs_d = '0;
                    res_min_d = '0;
                    res_max_d = '0;
                    if (op_mask != '0) begin
                        sel_d   = first_op(op_mask);
                        pend_d  = op_mask & ~op_bit(first_op(op_mask));
                        state_d = S_ISSUE;
                    end else begin
                        pend_d  = '0;
                        state_d = S_DONE;
                    end
                end
            end

            S_ISSUE: begin
                state_d = S_CAPT;
            end

            S_CAPT: begin
                case (sel_q)
                    OP_ABS:  res_abs_d = alu_out;
                    OP_MIN:  res_min_d = alu_out;
                    OP_MAX:  res_max_d = alu_out;
                    default: ;
                endcase
                if (pend_q != '0) begin
                    sel_d   = first_op(pend_q);
                    pend_d  = pend_q & ~op_bit(first_op(pend_q));
                    state_d = S_ISSUE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end

            S_DONE: begin
                // A zero-mask transaction arrives with out_valid low and raises it one cycle later.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign res_abs   = res_abs_q;
    assign res_min   = res_min_q;
    assign res_max   = res_max_q;

endmodule

// File: doc/amm_issue_ctrl.md
AMM_ISSUE_CTRL -- requirements
Module: amm_issue_ctrl

Interface
REQ-001 SHALL have one clock, clk, and an asynchronous, active-high reset, rst; no other clock or reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a_in, b_in  input  8 each  signed two's-complement operands.
REQ-007 op_mask  input  3  bit0 ABS, bit1 MIN, bit2 MAX; sampled at accept.
REQ-008 alu_a, alu_b  output  8 each  operands driven to the registered abs/min/max ALU.
REQ-009 alu_sel  output  2  ALU select code.
REQ-010 alu_out  input  8  ALU result; valid one cycle after issue.
REQ-011 res_abs, res_min, res_max  output  8 each  captured results.
REQ-012 out_valid  output  1  result set available; out_ready  input  1  consumer accepts.

Function
REQ-013 Select codes SHALL be ABS=2'b00 (|b|), MIN=2'b01, MAX=2'b10; 2'b11 never driven.
REQ-014 Accept SHALL occur on a rising edge with in_valid && in_ready; a_in, b_in and op_mask are latched into internal registers at that edge.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid while busy is ignored with no state change.
REQ-016 States SHALL be IDLE, ISSUE, CAPT, DONE.
- IDLE -> ISSUE on accept with nonzero mask.
- IDLE -> DONE on accept with zero mask.
REQ-017 Ops SHALL execute in fixed order ABS, MIN, MAX, skipping ops whose mask bit is 0.
REQ-018 In ISSUE, alu_sel SHALL be the current op code; state goes to CAPT next cycle.
REQ-019 In CAPT, alu_sel SHALL hold; at the end of CAPT, alu_out SHALL be written to the matching res_* register.
- State then goes to ISSUE for the next enabled op, or DONE if none remain.
REQ-020 alu_a and alu_b SHALL always equal the latched operand registers.
REQ-021 Latency: out_valid SHALL rise 2N cycles after the accept edge for N enabled ops; with N=0, it rises 1 cycle after accept.
REQ-022 res_* for ops not enabled SHALL be 0 for that transaction; all res_* are cleared at accept.
REQ-023 In DONE, out_valid SHALL be 1 and res_* stable until out_valid && out_ready at an edge, then IDLE.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 No arithmetic in this block; widths pass 8 bits unchanged with no sign extension.

Reset
REQ-026 rst SHALL force immediately, regardless of clk:
- state IDLE, in_ready=1, out_valid=0;
- res_*=0, alu_a=alu_b=0, alu_sel=2'b00.
REQ-027 rst mid-transaction SHALL abandon it with no partial out_valid.
- The first accept after rst deasserts is handled normally.

Structure
REQ-028 A shared package amm_pkg SHALL hold op-code constants (ABS/MIN/MAX), state encoding, and the data width constant 8.
REQ-029 Single module, no sub-module; the ALU is instantiated beside this block by the parent, not inside it.

Verification
REQ-030 Bench SHALL pair the block with the real ALU and cover:
- a_in=8'hFB (-5), b_in=8'h03, mask=3'b111 -> out_valid 6 cycles after accept; res_abs=03, res_min=FB, res_max=03.
- a_in=8'h10, b_in=8'hF0 (-16), mask=3'b001 -> out_valid after 2 cycles; res_abs=10, res_min=res_max=00; alu_sel only 00.
- mask=3'b000 -> out_valid 1 cycle after accept; all res_* = 00.
- out_ready held low 5 cycles in DONE -> out_valid and res_* stable; a new in_valid is ignored (in_ready=0); IDLE one cycle after out_ready.
- rst pulse in second CAPT of a mask=111 transaction -> out_valid=0, res_*=00, in_ready=1 immediately; next transaction (a=8'h7F, b=8'h80, mask=110) gives res_min=80, res_max=7F.
- back-to-back: in_valid held high across two transactions -> second accepted only in the IDLE cycle after the DONE handshake.
